// File: rtl/fifo_umbral.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds and an error flag.
// Define FIFO_UMBRAL_ERR_STICKY_EN to make err_sig hold until reset instead of pulsing.
module fifo_umbral #(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  input  logic [ADDR_W-1:0] full_umbral_in,
  input  logic [ADDR_W-1:0] empty_umbral_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic              err_sig,
  output logic [ADDR_W:0]   count
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FullCnt = (ADDR_W + 1)'(Depth);

  logic [DATA_W-1:0] r_mem [Depth];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_data_out;
  logic              r_valid;
  logic              r_err;

  logic w_pop_ok;
  logic w_push_ok;
  logic w_err;

  // Flags derive from the count register only, so they never glitch on push/pop.
  always_comb begin
    fifo_empty   = (r_count == '0);
    fifo_full    = (r_count == FullCnt);
    almost_full  = (r_count >= {1'b0, full_umbral_in});
    almost_empty = (r_count <= {1'b0, empty_umbral_in});
  end

  always_comb begin
    w_pop_ok  = pop && !fifo_empty;
    // A pop on the same edge frees a slot, so a full FIFO can still accept the push.
    w_push_ok = push && (!fifo_full || w_pop_ok);
    w_err     = (push && fifo_full && !w_pop_ok) || (pop && fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (w_push_ok && !reset) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_valid <= w_pop_ok;
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop_ok) begin
        r_data_out <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + ADDR_W'(1);
      end
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (ADDR_W + 1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
`ifdef FIFO_UMBRAL_ERR_STICKY_EN
      r_err <= r_err || w_err;
`else
      r_err <= w_err;
`endif
    end
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid;
  assign err_sig   = r_err;
  assign count     = r_count;

endmodule
